esm_instr_buffer: RTL
=====================

# esm_instr_buffer

Instruction buffer and dependency tracker that feeds the ESM core's independent-instruction selector and retires the slot it chooses. It accepts decoded instructions into `bs` slots and publishes a registered bitmask of slots free of hazards against older occupants. It consumes the core's `next_buffer_index`/`valid_count` choice, issues that slot downstream, frees it, and returns `proceed` with the issued `buffer_index`. It sits between decode and execute, in front of the core's mapping table.

## Interface
Parameters:
- `bs`, 16, number of buffer slots (power of two, ≥2)
- `rw`, 5, register-address width
- `iw`, 32, opaque instruction payload width

Ports:
- `clk`, in, 1, single clock, rising edge
- `rst`, in, 1, reset, synchronous, active-low
- `in_valid`, in, 1, incoming instruction valid
- `in_ready`, out, 1, a free slot exists
- `in_rd` / `in_rs1` / `in_rs2`, in, `rw` each, destination and source registers
- `in_payload`, in, `iw`, instruction bits, stored untouched
- `independent_instr`, out, `[0:bs-1]`, registered mask; bit i = slot i is valid and hazard-free
- `next_buffer_index`, in, `$clog2(bs)`, slot chosen by the core
- `valid_count`, in, 1, `next_buffer_index` is meaningful
- `proceed`, out, 1, one-cycle pulse after an issue
- `buffer_index`, out, `$clog2(bs)`, slot issued by the most recent issue, held until the next issue
- `out_valid`, out, 1, issue request to execute
- `out_ready`, in, 1, execute accepts
- `out_payload` / `out_rd`, out, `iw` / `rw`, issued instruction
- `occupancy`, out, `$clog2(bs)+1`, number of valid slots

## Operation
- **Allocation.**
  - `in_ready` = any slot free.
  - On `in_valid && in_ready`, write into the lowest-index free slot.
  - Set its valid bit.
  - Mark it younger than every currently valid slot in the age matrix.
- **Age matrix.** `bs`×`bs` bits. `older[j][i]`=1 means slot j was allocated before slot i.
  - Row and column of a slot are cleared when it is freed.
- **Hazard.** Slot i is dependent if some valid j with `older[j][i]` satisfies any of:
  - RAW: `rd_j` == `rs1_i` or `rs2_i`
  - WAW: `rd_j` == `rd_i`
  - WAR: `rs1_j` or `rs2_j` == `rd_i`
- **Mask.** `independent_instr[i]` = `valid_i` && !dependent_i, registered every cycle.
- **Issue.**
  - `out_valid` (combinational) = `valid_count` && `independent_instr[next_buffer_index]` && `valid[next_buffer_index]`.
  - `out_*` are driven from slot `next_buffer_index`.
  - On `out_valid && out_ready`, the slot is cleared at the clock edge.
  - At that same edge, `proceed` registers to 1 for one cycle and `buffer_index` registers the issued index.
- **Occupancy.** `occupancy` increments on allocate and decrements on issue. When both happen in one cycle it is unchanged.

## Timing
- **Reset** (`rst`=0 at an edge): all valid bits, the age matrix, `independent_instr`, `proceed`, `buffer_index` and `occupancy` are set to 0.
  - Consequently `in_ready`=1 and `out_valid`=0 from the first cycle after reset.
  - Reset mid-operation drops every entry; no issue completes in the reset cycle.
- **Mask latency.** `independent_instr` reflects slot state from the previous edge. An instruction written at edge N appears in the mask after edge N+1, i.e. 1-cycle latency.
- **Issue → proceed.** A handshake in cycle N gives `proceed`=1 in cycle N+1 only. Back-to-back issues give back-to-back pulses.
- **Stale mask guard.** The mask bit for a freed slot stays set for one cycle after the slot is freed. `out_valid` also requires the live valid bit, so a slot is never issued twice.
- **Simultaneous allocate and issue.** Both are allowed in the same cycle. A slot freed in cycle N is not allocatable until cycle N+1; the free list uses registered valid bits.
- **Full.** When `occupancy`==`bs`, `in_ready`=0. When full and an issue occurs in the same cycle, `in_ready` rises in the next cycle.
- **Empty.** `independent_instr`=0 and `out_valid`=0 regardless of `valid_count`.
- **Invalid choice.** If `valid_count`=1 but the chosen bit is 0, there is no issue and no error.

## Configuration
- **`ESM_X0_BYPASS_EN` defined:** register address 0 never creates a hazard. Every comparison is qualified with a non-zero register address.
- **Undefined:** all register addresses, including 0, are compared.

## Structure
- **Package `esm_pkg`:**
  - `esm_entry_t` struct: valid, rd, rs1, rs2, payload
  - default `BS` and `RW` localparams
  - `SLOT_W` = `$clog2(BS)`
- **Sub-module `esm_hazard_check`:** combinational, one instance per ordered slot pair. Inputs are the two entries; output is a hazard bit. The `ESM_X0_BYPASS_EN` qualification lives here.
- **Top level:** allocator, age matrix, mask register, issue logic.

## Test plan
- **Reset.** Hold `rst`=0 for 3 cycles → `in_ready`=1, `independent_instr`=0, `occupancy`=0, `proceed`=0.
- **Independent pair.** Write r1←r2 then r3←r4, with `valid_count`=0 → `independent_instr`=1100…0 two cycles after the second write; `occupancy`=2.
- **RAW chain and issue.**
  - Write r1←r2 (slot0), then r5←r1 (slot1) → mask=1000….
  - Drive `next_buffer_index`=0, `valid_count`=1, `out_ready`=1 → `proceed` pulses with `buffer_index`=0 → mask=0100… one cycle later.
- **Full.**
  - Fill 16 slots → `in_ready`=0.
  - Issue slot 5 with `in_valid` held → the next write lands in slot 5 one cycle later.
- **Stale/invalid choice.** Set `next_buffer_index` to an empty slot with `valid_count`=1 → `out_valid`=0, no `proceed`, `occupancy` unchanged.
- **x0 macro.** Write r0←r2 then r3←r0:
  - with `ESM_X0_BYPASS_EN` defined → mask 1100…
  - without it → mask 1000…

Source files
------------

// File: rtl/esm_pkg.sv
// esm_pkg
// Shared definitions for the ESM instruction buffer.
//   BS     : default number of buffer slots
//   RW     : default register-address width
//   IW     : default opaque payload width
//   SLOT_W : width of a slot index for the default slot count
//   esm_entry_t : one buffer slot (valid flag, registers, payload)
// Configuration macro used by the buffer: ESM_X0_BYPASS_EN (see esm_hazard_check).
package esm_pkg;

  localparam int BS     = 16;
  localparam int RW     = 5;
  localparam int IW     = 32;
  localparam int SLOT_W = $clog2(BS);

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [IW-1:0] payload;
  } esm_entry_t;

endpackage

// File: rtl/esm_hazard_check.sv
// esm_hazard_check
// Combinational hazard test for one ordered slot pair (older slot j, younger slot i).
// Ports:
//   older_en                       : slot j is valid and was allocated before slot i
//   older_rd/older_rs1/older_rs2   : registers of slot j
//   young_rd/young_rs1/young_rs2   : registers of slot i
//   hazard                         : slot i depends on slot j (RAW, WAW or WAR)
// Configuration: with ESM_X0_BYPASS_EN defined, register address 0 never matches.
module esm_hazard_check
  import esm_pkg::*;
#(
  parameter int rw = RW
) (
  input  logic          older_en,
  input  logic [rw-1:0] older_rd,
  input  logic [rw-1:0] older_rs1,
  input  logic [rw-1:0] older_rs2,
  input  logic [rw-1:0] young_rd,
  input  logic [rw-1:0] young_rs1,
  input  logic [rw-1:0] young_rs2,
  output logic          hazard
);

  // Register-address equality, optionally ignoring the hard-wired zero register.
  function automatic logic reg_eq(input logic [rw-1:0] a, input logic [rw-1:0] b);
`ifdef ESM_X0_BYPASS_EN
    return (a == b) && (a != {rw{1'b0}});
`else
    return (a == b);
`endif
  endfunction

  logic raw;
  logic waw;
  logic war;

  assign raw    = reg_eq(older_rd, young_rs1) | reg_eq(older_rd, young_rs2);
  assign waw    = reg_eq(older_rd, young_rd);
  assign war    = reg_eq(older_rs1, young_rd) | reg_eq(older_rs2, young_rd);
  assign hazard = older_en & (raw | waw | war);

endmodule

// File: rtl/esm_instr_buffer.sv
// esm_instr_buffer
// Instruction buffer and dependency tracker between decode and execute.
// Decoded instructions are written into the lowest free slot; an age matrix
// orders the occupants and a registered mask publishes slots with no hazard
// against any older occupant. The core picks a slot, which is issued and freed.
// Ports:
//   clk, rst (synchronous, active-low)
//   in_valid/in_ready, in_rd/in_rs1/in_rs2/in_payload : allocation side
//   independent_instr [0:bs-1] : registered mask, bit i = slot i valid and hazard-free
//   next_buffer_index, valid_count : slot choice from the core
//   proceed, buffer_index          : one-cycle pulse and index of the last issue
//   out_valid/out_ready, out_payload/out_rd : issue side (out_valid combinational)
//   occupancy                      : number of valid slots
// Configuration macro: ESM_X0_BYPASS_EN (register 0 never creates a hazard).
module esm_instr_buffer
  import esm_pkg::*;
#(
  parameter int bs = BS,
  parameter int rw = RW,
  parameter int iw = IW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [rw-1:0]         in_rd,
  input  logic [rw-1:0]         in_rs1,
  input  logic [rw-1:0]         in_rs2,
  input  logic [iw-1:0]         in_payload,
  output logic [0:bs-1]         independent_instr,
  input  logic [$clog2(bs)-1:0] next_buffer_index,
  input  logic                  valid_count,
  output logic                  proceed,
  output logic [$clog2(bs)-1:0] buffer_index,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [iw-1:0]         out_payload,
  output logic [rw-1:0]         out_rd,
  output logic [$clog2(bs):0]   occupancy
);

  localparam int sw = $clog2(bs);
  localparam logic [sw:0] occ_one = {{sw{1'b0}}, 1'b1};

  logic [bs-1:0]    valid;
  logic [rw-1:0]    slot_rd      [bs];
  logic [rw-1:0]    slot_rs1     [bs];
  logic [rw-1:0]    slot_rs2     [bs];
  logic [iw-1:0]    slot_payload [bs];
  // older[j][i] = slot j was allocated before slot i
  logic [bs-1:0]    older        [bs];
  logic [bs*bs-1:0] hz;
  logic [bs-1:0]    dep;
  logic [sw-1:0]    free_idx;
  logic             has_free;
  logic             alloc;
  logic             issue;
  logic [bs-1:0]    alloc_vec;
  logic [bs-1:0]    issue_vec;

  // Lowest-index free slot, taken from registered valid bits only.
  always_comb begin
    free_idx = {sw{1'b0}};
    has_free = 1'b0;
    for (int k = bs - 1; k >= 0; k--) begin
      free_idx = valid[k] ? free_idx : k[sw-1:0];
      has_free = has_free | ~valid[k];
    end
  end

  assign in_ready    = has_free;
  assign alloc       = in_valid & has_free;
  // Live valid bit guards against the mask bit that lingers one cycle after a free.
  assign out_valid   = valid_count & independent_instr[next_buffer_index] & valid[next_buffer_index];
  assign issue       = out_valid & out_ready;
  assign out_payload = slot_payload[next_buffer_index];
  assign out_rd      = slot_rd[next_buffer_index];

  // One-hot allocate and issue slot vectors.
  always_comb begin
    alloc_vec = {bs{1'b0}};
    issue_vec = {bs{1'b0}};
    for (int k = 0; k < bs; k++) begin
      alloc_vec[k] = alloc & (free_idx == k[sw-1:0]);
      issue_vec[k] = issue & (next_buffer_index == k[sw-1:0]);
    end
  end

  // Pairwise hazard checkers; slot j is the candidate older occupant of slot i.
  for (genvar j = 0; j < bs; j++) begin : g_old
    for (genvar i = 0; i < bs; i++) begin : g_young
      if (i != j) begin : g_pair
        esm_hazard_check #(.rw(rw)) u_hazard (
          .older_en (valid[j] & older[j][i]),
          .older_rd (slot_rd[j]),
          .older_rs1(slot_rs1[j]),
          .older_rs2(slot_rs2[j]),
          .young_rd (slot_rd[i]),
          .young_rs1(slot_rs1[i]),
          .young_rs2(slot_rs2[i]),
          .hazard   (hz[j*bs+i])
        );
      end else begin : g_self
        assign hz[j*bs+i] = 1'b0;
      end
    end
  end

  // Slot i is dependent if any older valid slot hazards against it.
  always_comb begin
    dep = {bs{1'b0}};
    for (int i = 0; i < bs; i++) begin
      for (int j = 0; j < bs; j++) begin
        dep[i] = dep[i] | hz[j*bs+i];
      end
    end
  end

  // Valid bits: set on allocate, cleared on issue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= {bs{1'b0}};
    end else begin
      valid <= (valid & ~issue_vec) | alloc_vec;
    end
  end

  // Age matrix: a new slot is younger than every surviving occupant; a freed slot drops its row and column.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j < bs; j++) begin
        older[j] <= {bs{1'b0}};
      end
    end else begin
      for (int j = 0; j < bs; j++) begin
        for (int i = 0; i < bs; i++) begin
          if (alloc_vec[i]) begin
            older[j][i] <= valid[j] & ~issue_vec[j];
          end else if (alloc_vec[j] | issue_vec[i] | issue_vec[j]) begin
            older[j][i] <= 1'b0;
          end else begin
            older[j][i] <= older[j][i];
          end
        end
      end
    end
  end

  // Slot contents; qualified by the valid bits, so they need no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < bs; k++) begin
      if (alloc_vec[k]) begin
        slot_rd[k]      <= in_rd;
        slot_rs1[k]     <= in_rs1;
        slot_rs2[k]     <= in_rs2;
        slot_payload[k] <= in_payload;
      end else begin
        slot_rd[k]      <= slot_rd[k];
        slot_rs1[k]     <= slot_rs1[k];
        slot_rs2[k]     <= slot_rs2[k];
        slot_payload[k] <= slot_payload[k];
      end
    end
  end

  // Registered independence mask, issue pulse, issued index and occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      independent_instr <= {bs{1'b0}};
      proceed           <= 1'b0;
      buffer_index      <= {sw{1'b0}};
      occupancy         <= {(sw+1){1'b0}};
    end else begin
      for (int i = 0; i < bs; i++) begin
        independent_instr[i] <= valid[i] & ~dep[i];
      end
      proceed      <= issue;
      buffer_index <= issue ? next_buffer_index : buffer_index;
      case ({alloc, issue})
        2'b10:   occupancy <= occupancy + occ_one;
        2'b01:   occupancy <= occupancy - occ_one;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule
